// File: rtl/port_timer.sv
// port_timer: I/O-port mapped 16-bit down-counting timer with prescaler,
// one-shot/auto-reload modes, snapshot register and level interrupt.
module port_timer #(
    parameter logic [7:0]  BASE     = 8'h10,
    parameter int unsigned PRESCALE = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] pin_pa,
    input  logic [7:0] pin_po,
    input  logic       pin_pw,
    output logic [7:0] pin_pi,
    output logic       pin_intr
);
    localparam logic [15:0] PM1 = 16'(PRESCALE - 1);
    logic [15:0] reload, count, snap, presc;
    logic        en, auto_rl, ie, exp_f, run;
    logic [8:0]  off;
    logic [7:0]  rd;
    logic        wr, wr_ctrl, wr_stat, tick, expire, start, stop, oneshot_end;
    // Addresses below BASE wrap to a large offset and fall out of the map
    assign off         = {1'b0, pin_pa} - {1'b0, BASE};
    assign wr          = pin_pw && off < 9'd6;
    assign wr_ctrl     = wr && off == 9'd2;
    assign wr_stat     = wr && off == 9'd3;
    assign tick        = run && presc == PM1;
    assign expire      = tick && count == 16'd0;
    assign start       = wr_ctrl && pin_po[0] && !en;
    assign stop        = wr_ctrl && !pin_po[0];
    assign oneshot_end = expire && !auto_rl;
    always_comb begin
        rd = off == 9'd0 ? reload[7:0] :
             off == 9'd1 ? reload[15:8] :
             off == 9'd2 ? {5'b0, ie, auto_rl, en} :
             off == 9'd3 ? {6'b0, run, exp_f} :
             off == 9'd4 ? snap[7:0] :
             off == 9'd5 ? snap[15:8] : 8'hFF;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload   <= '0;
            count    <= '0;
            snap     <= '0;
            presc    <= '0;
            en       <= 1'b0;
            auto_rl  <= 1'b0;
            ie       <= 1'b0;
            exp_f    <= 1'b0;
            run      <= 1'b0;
            pin_pi   <= 8'h00;
            pin_intr <= 1'b0;
        end else begin
            if (wr && off == 9'd0) reload[7:0] <= pin_po;
            if (wr && off == 9'd1) reload[15:8] <= pin_po;
            if (wr && off == 9'd4) snap <= count;
            if (wr_ctrl) {ie, auto_rl} <= pin_po[2:1];
            en       <= (wr_ctrl ? pin_po[0] : en) & ~oneshot_end;
            run      <= start | (run & ~stop & ~oneshot_end);
            presc    <= (!run || start || stop || tick) ? '0 : presc + 16'd1;
            // A disabling CTRL write freezes COUNT even if it lands on a tick
            count    <= start ? reload :
                        (tick && !stop) ? (count == 16'd0 ? (auto_rl ? reload : count) : count - 16'd1) :
                        count;
            exp_f    <= expire | (exp_f & ~(wr_stat & pin_po[0]));
            pin_pi   <= rd;
            pin_intr <= exp_f & ie;
        end
    end
endmodule

// File: tb/tb_port_timer.sv
// tb_port_timer: vector table, timing sequences and randomized run against a
// behavioural model of the timer.
module tb_port_timer;
    localparam logic [7:0] BASE = 8'h10;
    localparam int P = 4;
    logic       clk = 1'b0, rst_n = 1'b0, pin_pw = 1'b0, pin_intr;
    logic [7:0] pin_pa = 8'h00, pin_po = 8'h00, pin_pi;
    int checks = 0, passed = 0;

    port_timer #(.BASE(BASE), .PRESCALE(P)) dut (
        .clk(clk), .rst_n(rst_n), .pin_pa(pin_pa), .pin_po(pin_po),
        .pin_pw(pin_pw), .pin_pi(pin_pi), .pin_intr(pin_intr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct packed {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] e;
    } vec_t;
    vec_t tbl [22];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pin_pa = a; pin_po = d; pin_pw = 1'b1;
        @(negedge clk);
        pin_pw = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        pin_pa = a; pin_pw = 1'b0;
        @(negedge clk);
        d = pin_pi;
    endtask

    task automatic rdchk(input string name, input logic [7:0] a, input logic [7:0] e);
        logic [7:0] v;
        rd(a, v);
        check(name, v, e);
    endtask

    task automatic run_table(input int n);
        for (int i = 0; i < n; i++)
            if (tbl[i].w) wr(tbl[i].a, tbl[i].d);
            else rdchk($sformatf("vec%0d", i), tbl[i].a, tbl[i].e);
    endtask

    // Edges until STATUS.EXP appears on pin_pi (pin_pa must already be 13h)
    task automatic poll(output int ke, output int ki);
        ke = 99; ki = 99;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (pin_intr && ki == 99) ki = k;
            if (pin_pi[0]) begin ke = k; break; end
        end
    endtask

    // Reference model: the prescaler phase is derived from the start edge
    logic [15:0] m_reload, m_count, m_snap;
    logic        m_en, m_auto, m_ie, m_exp, m_run, m_intr;
    logic [7:0]  m_pi;
    int          m_t0, e;

    function automatic logic [7:0] mrd(input logic [7:0] a);
        int r = int'(a) - int'(BASE);
        case (r)
            0: return m_reload[7:0];
            1: return m_reload[15:8];
            2: return {5'b0, m_ie, m_auto, m_en};
            3: return {6'b0, m_run, m_exp};
            4: return m_snap[7:0];
            5: return m_snap[15:8];
            default: return 8'hFF;
        endcase
    endfunction

    task automatic mreset();
        m_reload = 0; m_count = 0; m_snap = 0;
        m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0; m_run = 0;
        m_pi = 0; m_intr = 0; m_t0 = 0; e = 0;
    endtask

    task automatic mstep(input logic [7:0] a, input logic [7:0] d, input logic w);
        int r = int'(a) - int'(BASE);
        logic tick, expire, n_run, n_en, n_exp;
        logic [15:0] n_count;
        e++;
        m_pi = mrd(a);
        m_intr = m_exp & m_ie;
        tick = m_run && ((e - m_t0) % P == 0);
        expire = tick && m_count == 0;
        n_count = m_count; n_run = m_run; n_en = m_en; n_exp = m_exp;
        if (tick) begin
            if (m_count != 0) n_count = m_count - 1;
            else begin
                n_exp = 1;
                if (m_auto) n_count = m_reload;
                else begin n_run = 0; n_en = 0; end
            end
        end
        if (w)
            case (r)
                0: m_reload[7:0] = d;
                1: m_reload[15:8] = d;
                2: begin
                    if (d[0] && !m_en) begin n_count = m_reload; n_run = 1; n_en = 1; m_t0 = e; end
                    else if (!d[0]) begin n_run = 0; n_en = 0; n_count = m_count; end
                    m_auto = d[1]; m_ie = d[2];
                end
                3: if (d[0] && !expire) n_exp = 0;
                4: m_snap = m_count;
                default: ;
            endcase
        m_count = n_count; m_run = n_run; m_en = n_en; m_exp = n_exp;
    endtask

    initial begin
        int ke, ki;
        tbl = '{
            '{1'b0, 8'h10, 8'h00, 8'h00}, '{1'b0, 8'h11, 8'h00, 8'h00},
            '{1'b0, 8'h12, 8'h00, 8'h00}, '{1'b0, 8'h13, 8'h00, 8'h00},
            '{1'b0, 8'h14, 8'h00, 8'h00}, '{1'b0, 8'h15, 8'h00, 8'h00},
            '{1'b0, 8'h20, 8'h00, 8'hFF}, '{1'b1, 8'h10, 8'hAB, 8'h00},
            '{1'b1, 8'h11, 8'hCD, 8'h00}, '{1'b0, 8'h10, 8'h00, 8'hAB},
            '{1'b0, 8'h11, 8'h00, 8'hCD}, '{1'b1, 8'h12, 8'hF6, 8'h00},
            '{1'b0, 8'h12, 8'h00, 8'h06}, '{1'b1, 8'h13, 8'hFF, 8'h00},
            '{1'b0, 8'h13, 8'h00, 8'h00}, '{1'b1, 8'h15, 8'h55, 8'h00},
            '{1'b0, 8'h15, 8'h00, 8'h00}, '{1'b1, 8'h0F, 8'h12, 8'h00},
            '{1'b0, 8'h0F, 8'h00, 8'hFF}, '{1'b1, 8'h14, 8'h00, 8'h00},
            '{1'b0, 8'h14, 8'h00, 8'h00}, '{1'b0, 8'h16, 8'h00, 8'hFF}
        };
        #1 check("rst_pi", pin_pi, 8'h00);
        check("rst_intr", pin_intr, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_table(22);
        check("idle_intr", pin_intr, 1'b0);

        // One-shot, RELOAD=3: expiry 16 edges after the CTRL write
        wr(8'h10, 8'h03); wr(8'h11, 8'h00); wr(8'h12, 8'h05);
        pin_pa = 8'h13;
        poll(ke, ki);
        check("oneshot_exp_edge", 16'(ke), 16'd17);
        check("oneshot_intr_edge", 16'(ki), 16'd17);
        rdchk("oneshot_status", 8'h13, 8'h01);
        rdchk("oneshot_ctrl", 8'h12, 8'h04);
        wr(8'h13, 8'h01);
        rdchk("w1c_status", 8'h13, 8'h00);
        check("w1c_intr", pin_intr, 1'b0);

        // Auto-reload RELOAD=1: expiry every 8 edges; W1C on an expire edge loses
        wr(8'h10, 8'h01); wr(8'h12, 8'h03);
        repeat (7) @(negedge clk);
        pin_pa = 8'h13; pin_po = 8'h01; pin_pw = 1'b1;
        @(negedge clk);
        pin_pw = 1'b0;
        rdchk("set_wins", 8'h13, 8'h03);
        wr(8'h13, 8'h01);
        rdchk("auto_cleared", 8'h13, 8'h02);
        poll(ke, ki);
        check("auto_next_exp", 16'(ke), 16'd3);
        wr(8'h12, 8'h00); wr(8'h13, 8'h01);

        // Snapshot: pre-tick capture
        wr(8'h10, 8'h34); wr(8'h11, 8'h12); wr(8'h12, 8'h01);
        wr(8'h14, 8'h00);
        rdchk("snap_lo0", 8'h14, 8'h34);
        rdchk("snap_hi0", 8'h15, 8'h12);
        @(negedge clk);
        pin_pa = 8'h14; pin_po = 8'h00; pin_pw = 1'b1;
        @(negedge clk);
        pin_pw = 1'b0;
        rdchk("snap_tick_lo", 8'h14, 8'h33);
        rdchk("snap_tick_hi", 8'h15, 8'h12);
        wr(8'h12, 8'h00);

        // RELOAD change mid-run: old period completes, new one follows
        wr(8'h10, 8'h02); wr(8'h11, 8'h00); wr(8'h12, 8'h03);
        wr(8'h10, 8'h00);
        pin_pa = 8'h13;
        poll(ke, ki);
        check("reload_old_period", 16'(ke), 16'd11);
        @(negedge clk);
        pin_po = 8'h01; pin_pw = 1'b1;
        @(negedge clk);
        pin_pw = 1'b0;
        poll(ke, ki);
        check("reload_new_period", 16'(ke), 16'd3);
        wr(8'h12, 8'h00); wr(8'h13, 8'h01);

        // Reset mid-count aborts everything
        wr(8'h10, 8'h05); wr(8'h12, 8'h07);
        pin_pa = 8'h13;
        poll(ke, ki);
        check("pre_rst_exp", 16'(ke), 16'd25);
        check("pre_rst_intr", 16'(ki), 16'd25);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1 check("async_rst_pi", pin_pi, 8'h00);
        check("async_rst_intr", pin_intr, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_table(7);
        check("post_rst_intr", pin_intr, 1'b0);
        pin_pa = 8'h13;
        poll(ke, ki);
        check("post_rst_no_exp", 16'(ke), 16'd99);

        // Randomized traffic against the model
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mreset();
        for (int i = 0; i < 2000; i++) begin
            int r;
            logic [7:0] a, d;
            logic w;
            @(negedge clk);
            r = int'($urandom_range(0, 99));
            d = 8'($urandom);
            w = 1'b1;
            if (r < 6) a = 8'h12;
            else if (r < 12) begin a = 8'h10; d = 8'($urandom_range(0, 6)); end
            else if (r < 14) begin a = 8'h11; d = 8'($urandom_range(0, 1)); end
            else if (r < 20) a = 8'h13;
            else if (r < 26) a = 8'h14;
            else if (r < 30) a = 8'($urandom_range(8'h0C, 8'h17));
            else begin a = 8'($urandom_range(8'h0E, 8'h17)); w = 1'b0; end
            pin_pa = a; pin_po = d; pin_pw = w;
            mstep(a, d, w);
            @(posedge clk); #1;
            check("rnd_pi", pin_pi, m_pi);
            check("rnd_intr", pin_intr, m_intr);
        end
        pin_pw = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/port_timer.md
PORT_TIMER -- requirements
Module: port_timer

Interface
REQ-001 SHALL have parameter BASE, default 8'h10, giving the first of six consecutive I/O port addresses (BASE+0..BASE+5).
REQ-002 SHALL have parameter PRESCALE, default 25, giving clk cycles per timer tick (range 1..65535).
REQ-003 clk  in  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 pin_pa  in  8  CPU port address.
REQ-006 pin_po  in  8  CPU port write data.
REQ-007 pin_pw  in  1  CPU port write strobe; a write occurs on each clk edge where it is high.
REQ-008 pin_pi  out  8  port read data to CPU, registered.
REQ-009 pin_intr  out  1  interrupt request to CPU, registered, active-high level.

Function
REQ-010 Register map SHALL be:
- BASE+0 RELOAD_LO (r/w)
- BASE+1 RELOAD_HI (r/w)
- BASE+2 CTRL (r/w): bit0 EN, bit1 AUTO, bit2 IE; bits 7:3 read 0
- BASE+3 STATUS: read bit0 EXP, bit1 RUN; write-1 to bit0 clears EXP
- BASE+4 SNAP_LO (r); any write to BASE+4 copies the 16-bit COUNT into SNAP
- BASE+5 SNAP_HI (r)
REQ-011 pin_pi SHALL present the addressed register's value one clk after pin_pa is sampled; unmapped addresses SHALL read 8'hFF.
REQ-012 Reads SHALL have no side effects; writes to read-only bits or unmapped addresses SHALL be ignored.
REQ-013 Prescaler: 16-bit counter; while RUN, counts 0..PRESCALE-1 and emits a one-clk tick on wrap; held at 0 while not RUN.
REQ-014 A CTRL write taking EN 0->1 SHALL, on that edge, load COUNT from RELOAD, clear prescaler, set RUN.
REQ-015 A CTRL write with EN already 1 and written 1 SHALL NOT restart COUNT or prescaler.
REQ-016 A CTRL write with EN=0 SHALL clear RUN on that edge; COUNT SHALL hold its value.
REQ-017 On a tick with COUNT != 0: COUNT <= COUNT-1.
REQ-018 On a tick with COUNT == 0: EXP <= 1; if AUTO, COUNT <= RELOAD and RUN stays 1; else RUN <= 0 and EN <= 0, COUNT stays 0.
REQ-019 Period SHALL therefore be (RELOAD+1)*PRESCALE clks; RELOAD=0 expires every tick.
REQ-020 RELOAD writes while running SHALL take effect only at the next reload or restart.
REQ-021 Simultaneous expire and STATUS W1C in one cycle: EXP SHALL end at 1 (set wins).
REQ-022 pin_intr SHALL equal registered (EXP & IE), i.e. valid one clk after EXP or IE changes.
REQ-023 SNAP write coinciding with a tick SHALL capture COUNT before the decrement.

Reset
REQ-024 While rst_n low: RELOAD, CTRL, EXP, RUN, COUNT, SNAP, prescaler = 0; pin_pi = 8'h00; pin_intr = 0.
REQ-025 Reset asserted mid-count SHALL abort immediately; after release the timer is idle until a new EN 0->1 write.

Verification (bench PRESCALE=4, BASE=8'h10)
REQ-026 Reset release, read ports 10h..15h and 20h -> 00,00,00,00,00,00,FF; pin_intr=0.
REQ-027 Write 10h=03, 11h=00, 12h=05 (EN,IE, one-shot) -> EXP and pin_intr rise 16 clks (+1 for pin_intr) after CTRL write; STATUS then reads 01, CTRL reads 04.
REQ-028 Write 12h=03 (EN,AUTO), RELOAD=0001 -> EXP sets every 8 clks; W1C 13h=01 issued on an expire cycle leaves STATUS bit0=1.
REQ-029 RELOAD=1234 running; write 14h on chosen cycle -> 14h/15h return the pre-tick count (e.g. 34,12 before first tick); change RELOAD mid-run -> old period completes, new value used after reload.
REQ-030 Running timer, pull rst_n low for 1 clk mid-count -> all registers 0, pin_intr 0, no further expiry until EN rewritten.
